// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The adder sits on the slave side; whoever feeds operands and drains results is the master.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: latches two operands, adds them LSB-first one bit per clock with a
// registered carry, then holds the sum and carry-out until the result is taken.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_a, w_a_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic [WIDTH-1:0] r_sum, w_sum_d;
  logic [WIDTH-1:0] r_out_sum, w_out_sum_d;
  logic             r_carry, w_carry_d;
  logic             r_out_carry, w_out_carry_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             w_s;
  logic             w_last;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_last = (r_cnt == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_out_sum   <= '0;
      r_carry     <= 1'b0;
      r_out_carry <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_a         <= w_a_d;
      r_b         <= w_b_d;
      r_sum       <= w_sum_d;
      r_out_sum   <= w_out_sum_d;
      r_carry     <= w_carry_d;
      r_out_carry <= w_out_carry_d;
      r_cnt       <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_a_d         = r_a;
    w_b_d         = r_b;
    w_sum_d       = r_sum;
    w_out_sum_d   = r_out_sum;
    w_carry_d     = r_carry;
    w_out_carry_d = r_out_carry;
    w_cnt_d       = r_cnt;
    case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_a_d     = bus.in_a;
          w_b_d     = bus.in_b;
          w_carry_d = 1'b0;
          w_cnt_d   = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        w_carry_d = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
        // Sum bits enter at the MSB so after WIDTH steps bit 0 lands at position 0.
        w_sum_d   = (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
        w_a_d     = r_a >> 1;
        w_b_d     = r_b >> 1;
        w_cnt_d   = r_cnt + CntW'(1);
        if (w_last) begin
          // Output registers only change here, so they stay frozen through IDLE and RUN.
          w_out_sum_d   = w_sum_d;
          w_out_carry_d = w_carry_d;
          w_state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.busy      = (r_state != StIdle);
  assign bus.out_sum   = r_out_sum;
  assign bus.out_carry = r_out_carry;
endmodule
